// File: rtl/screen_pkg.sv
// rtl/screen_pkg.sv - shared screen state type and pixel select helper
package screen_pkg;

  typedef enum logic [1:0] {ST_WELCOME, ST_PLAY, ST_WIN, ST_LOSE} SCREEN_STATE;

  function automatic logic [7:0] rgb_select(
    input SCREEN_STATE s,
    input logic [7:0]  rgb_main,
    input logic [7:0]  rgb_welcome,
    input logic [7:0]  rgb_win,
    input logic [7:0]  rgb_lose
  );
    case (s)
      ST_WELCOME: rgb_select = rgb_welcome;
      ST_PLAY:    rgb_select = rgb_main;
      ST_WIN:     rgb_select = rgb_win;
      default:    rgb_select = rgb_lose;
    endcase
  endfunction

endpackage

// File: rtl/screen_edge_detector.sv
// rtl/screen_edge_detector.sv - rising-edge pulse on a level input
module edge_detector #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb prev_d = din;

  // RESET_VAL=1 suppresses a pulse from a level already high when reset releases
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= RESET_VAL;
    else        prev_q <= prev_d;
  end

  assign rise = din & ~prev_q;

endmodule

// File: rtl/screen_controller.sv
// rtl/screen_controller.sv - welcome/play/win/lose flow and VGA pixel select
module screen_controller
  import screen_pkg::*;
#(
  parameter int WIN_SCORE          = 10,
  parameter int ARM_FRAMES         = 2,
  parameter int HOLD_FRAMES        = 120,
  parameter int AUTO_RETURN_FRAMES = 600
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       key5IsPressed,
  input  logic [3:0] life,
  input  logic [3:0] score,
  input  logic [7:0] RGB_screen_main,
  input  logic [7:0] RGB_screen_welcome,
  input  logic [7:0] RGB_screen_win,
  input  logic [7:0] RGB_screen_lose,
  output logic [7:0] RGBOut,
  output logic       start,
  output logic       gameResetN,
  output logic [1:0] gameState
);

  localparam int FC_W = $clog2(AUTO_RETURN_FRAMES + 1);
  localparam logic [FC_W-1:0] FC_ARM  = FC_W'(ARM_FRAMES);
  localparam logic [FC_W-1:0] FC_HOLD = FC_W'(HOLD_FRAMES);
  localparam logic [FC_W-1:0] FC_AUTO = FC_W'(AUTO_RETURN_FRAMES);

  SCREEN_STATE     state_q, state_d;
  logic [FC_W-1:0] frame_count_q, frame_count_d;
  logic [7:0]      rgb_q, rgb_d;
  logic            start_q, start_d;
  logic            game_reset_n_q, game_reset_n_d;
  logic            key_rise;
  logic            score_win;

  edge_detector #(.RESET_VAL(1'b1)) u_key5_edge (
    .clk   (clk),
    .rst_n (resetN),
    .din   (key5IsPressed),
    .rise  (key_rise)
  );

  assign score_win = ({28'd0, score} >= 32'(WIN_SCORE));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WELCOME: if (key_rise) state_d = ST_PLAY;
      ST_PLAY: begin
        if (startOfFrame && (frame_count_q >= FC_ARM)) begin
          if (life == 4'd0)   state_d = ST_LOSE;
          else if (score_win) state_d = ST_WIN;
        end
      end
      ST_WIN, ST_LOSE: begin
        if ((key_rise && (frame_count_q >= FC_HOLD)) || (frame_count_q == FC_AUTO))
          state_d = ST_WELCOME;
      end
      default: state_d = ST_WELCOME;
    endcase

    // A state change wins over a coincident frame pulse: the count restarts at 0
    if (state_d != state_q)
      frame_count_d = '0;
    else if (startOfFrame && (frame_count_q != FC_AUTO))
      frame_count_d = frame_count_q + FC_W'(1);
    else
      frame_count_d = frame_count_q;

    rgb_d          = rgb_select(state_q, RGB_screen_main, RGB_screen_welcome,
                                RGB_screen_win, RGB_screen_lose);
    start_d        = (state_d == ST_PLAY) && (state_q != ST_PLAY);
    game_reset_n_d = (state_d != ST_WELCOME);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= ST_WELCOME;
      frame_count_q  <= '0;
      rgb_q          <= 8'h00;
      start_q        <= 1'b0;
      game_reset_n_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_count_q  <= frame_count_d;
      rgb_q          <= rgb_d;
      start_q        <= start_d;
      game_reset_n_q <= game_reset_n_d;
    end
  end

  assign RGBOut     = rgb_q;
  assign start      = start_q;
  assign gameResetN = game_reset_n_q;
  assign gameState  = state_q;

endmodule

// File: doc/screen_controller.md
# screen_controller

Top-level game flow controller sitting directly downstream of the main play screen. Consumes the main screen's pixel stream plus its `life`/`score` outputs and the pixel streams of the welcome, win and lose screens. Runs the WELCOME → PLAY → WIN/LOSE → WELCOME state machine and generates the main screen's `start` pulse and game-scoped reset. Drives the single registered RGB stream to the VGA output.

## Interface
Parameters:
- `WIN_SCORE`, default 10: score at or above which the game is won.
- `ARM_FRAMES`, default 2: frames in PLAY before the win/lose checks are enabled.
- `HOLD_FRAMES`, default 120: minimum frames an end screen is shown before `key5` is accepted.
- `AUTO_RETURN_FRAMES`, default 600: frames after which an end screen returns to WELCOME unprompted. Must exceed `HOLD_FRAMES`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system/pixel clock.
- `resetN` in 1: asynchronous active-low reset.
- `startOfFrame` in 1: one-cycle pulse per video frame.
- `key5IsPressed` in 1: level, start/continue key.
- `life` in 4: remaining lives from the main screen.
- `score` in 4: score from the main screen.
- `RGB_screen_main` in 8: main screen pixel.
- `RGB_screen_welcome` in 8: welcome screen pixel.
- `RGB_screen_win` in 8: win screen pixel.
- `RGB_screen_lose` in 8: lose screen pixel.
- `RGBOut` out 8: selected pixel to the VGA block.
- `start` out 1: one-cycle pulse to the main screen `start` input.
- `gameResetN` out 1: active-low reset for the main screen.
- `gameState` out 2: current state, for debug and LEDs.

## Operation
- States: WELCOME=0, PLAY=1, WIN=2, LOSE=3.
- Key edge: `keyRise = key5IsPressed & ~key5Prev`. `key5Prev` is registered and resets to 1, so a key held through reset never triggers.
- `frameCount` rules:
  - Clears to 0 on every state change.
  - Otherwise increments on `startOfFrame`.
  - Saturates at `AUTO_RETURN_FRAMES`.
  - Width is `$clog2(AUTO_RETURN_FRAMES+1)`.
- Transitions (all at a clock edge):
  - WELCOME → PLAY on `keyRise`.
  - PLAY: win/lose is evaluated only on a `startOfFrame` cycle with `frameCount >= ARM_FRAMES`.
    - PLAY → LOSE if `life == 0`.
    - Otherwise PLAY → WIN if `score >= WIN_SCORE` (unsigned 4-bit compare).
    - If both hold in the same cycle, LOSE has priority.
  - WIN/LOSE → WELCOME on `keyRise` with `frameCount >= HOLD_FRAMES`, or when `frameCount == AUTO_RETURN_FRAMES`. A `keyRise` before `HOLD_FRAMES` is discarded, not queued.
- `gameResetN` is registered: 0 in WELCOME, 1 in PLAY/WIN/LOSE. The main screen therefore stays frozen, with score and life visible, behind the end screens.
- `start` is registered high for exactly the one cycle after the state becomes PLAY.
- RGB select is registered from the current state:
  - WELCOME → `RGB_screen_welcome`
  - PLAY → `RGB_screen_main`
  - WIN → `RGB_screen_win`
  - LOSE → `RGB_screen_lose`

## Timing
- Reset values: state WELCOME, `RGBOut` 8'h00, `start` 0, `gameResetN` 0, `gameState` 0, `frameCount` 0, `key5Prev` 1.
- `keyRise` in cycle T → state PLAY and `gameResetN`=1 at edge T+1 → `start`=1 during cycle T+1..T+2 only.
- RGB latency is one clock from the inputs, and from the state, to `RGBOut`. The switch-over takes effect on the pixel after the state edge; no frame alignment is performed.
- Win/lose detection latency: at most one frame after `life`/`score` change.
- `resetN` asserted mid-game returns all outputs to their reset values asynchronously, regardless of state. The next `keyRise` requires a fresh press.
- `startOfFrame` and `keyRise` in the same cycle: the transition is evaluated first. `frameCount` clears; it does not increment.

## Structure
- Shared package `screen_pkg`: `typedef enum logic [1:0] {ST_WELCOME, ST_PLAY, ST_WIN, ST_LOSE} SCREEN_STATE;`.
- Sub-module `edge_detector`: a rising-edge pulse on a level input, with a parameterised reset value for the previous sample. It is reused for the other key inputs later.
- The rest (state register, frame counter, output registers) lives in `screen_controller`.

## Test plan
- Reset with `key5IsPressed`=1 held, then release and press once → no PLAY until the press; the press at cycle T gives `gameState`=1 at T+1 and `start`=1 for one cycle.
- PLAY with `life`=0 at the first `startOfFrame` → stays PLAY (not armed); at frame 2 → LOSE; `RGBOut` follows `RGB_screen_lose` one clock later.
- PLAY, `score`=10 and `life`=0 in the same frame → LOSE. `score`=10 with `life`=2 → WIN.
- WIN, key pressed at frame 50 → ignored, stays WIN; pressed at frame 120 → WELCOME, `gameResetN`=0.
- LOSE with no key → WELCOME exactly at frame 600.
- Async `resetN` pulse during PLAY between clock edges → `RGBOut`=0, `gameResetN`=0 and `gameState`=0 immediately.
